// File: rtl/uart_tx_buffered.sv
// AXI4-Stream to UART transmitter: start bit, DATA_WIDTH data bits LSB first, stop bit.
// A one-word holding register lets the next frame follow the current one with no idle gap.
module uart_tx_buffered #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  txd,
    output logic                  busy,
    input  logic [15:0]           prescale
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    state_t                state_q, state_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [18:0]           prs_cnt_q, prs_cnt_d;
    logic [18:0]           period_q, period_d;
    logic                  txd_q, txd_d;
    logic                  rdy_en_q;

    logic                  accept;
    logic                  bit_done;
    logic                  load;
    logic [15:0]           eff_prescale;

    assign s_axis_tready = rdy_en_q && !hold_valid_q;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign bit_done      = (prs_cnt_q == period_q - 19'd1);
    assign eff_prescale  = (prescale == 16'd0) ? 16'd1 : prescale;
    assign txd           = txd_q;
    assign busy          = (state_q != S_IDLE);

    always_comb begin
        state_d      = state_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        prs_cnt_d    = prs_cnt_q;
        period_d     = period_q;
        load         = 1'b0;

        if (state_q != S_IDLE) begin
            prs_cnt_d = bit_done ? 19'd0 : prs_cnt_q + 19'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (hold_valid_q) load = 1'b1;
            end
            S_START: begin
                if (bit_done) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 4'd0;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) state_d = S_STOP;
                    else                       bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    if (hold_valid_q) load = 1'b1;
                    else              state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bit period is latched here so prescale changes only affect the next frame.
        if (load) begin
            state_d      = S_START;
            shift_d      = hold_data_q;
            period_d     = {eff_prescale, 3'b000};
            prs_cnt_d    = 19'd0;
            bit_cnt_d    = 4'd0;
            hold_valid_d = 1'b0;
        end

        if (accept) begin
            hold_valid_d = 1'b1;
            hold_data_d  = s_axis_tdata;
        end
    end

    // txd is re-registered from the current state, so the line trails the FSM by one cycle.
    always_comb begin
        case (state_q)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_q[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= 4'd0;
            prs_cnt_q    <= 19'd0;
            period_q     <= 19'd0;
            txd_q        <= 1'b1;
            rdy_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            prs_cnt_q    <= prs_cnt_d;
            period_q     <= period_d;
            txd_q        <= txd_d;
            rdy_en_q     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: stimulus pushes expected frames, a line monitor decodes txd and checks them.
module tb_uart_tx_buffered;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_axis_tdata = 8'h00;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        txd;
    logic        busy;
    logic [15:0] prescale = 16'd1;

    int checks = 0;
    int failures = 0;
    int pcyc = 0;
    int ncyc = 0;

    typedef struct {
        logic [7:0] d;
        int         p;
        bit         b2b;
    } exp_t;
    exp_t sb[$];

    uart_tx_buffered #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .txd(txd), .busy(busy), .prescale(prescale)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pcyc <= pcyc + 1;

    // Line monitor: acts as the receiving end, comparing every cycle of each frame to the expected level.
    bit   mon_active = 0;
    bit   rogue = 0;
    int   mon_cnt = 0;
    int   mon_bad = 0;
    int   end_cyc = -10;
    exp_t cur;

    always @(negedge clk) begin
        int  idx;
        logic eb;
        ncyc = ncyc + 1;
        if (!rst_n) begin
            mon_active = 0;
            rogue = 0;
            sb.delete();
        end else begin
            if (rogue && txd === 1'b1) rogue = 0;
            if (!mon_active && !rogue && txd === 1'b0) begin
                if (sb.size() == 0) begin
                    checks++; failures++; rogue = 1;
                    $display("FAIL unexpected_start cycle=%0d txd=0 required idle 1", ncyc);
                end else begin
                    cur = sb.pop_front();
                    mon_active = 1; mon_cnt = 0; mon_bad = 0;
                    if (cur.b2b) begin
                        checks++;
                        if (ncyc != end_cyc + 1) begin
                            failures++;
                            $display("FAIL frame_gap data=%h gap=%0d required 0", cur.d, ncyc - end_cyc - 1);
                        end
                    end
                end
            end
            if (mon_active) begin
                idx = mon_cnt / cur.p;
                if (idx == 0)      eb = 1'b0;
                else if (idx <= 8) eb = cur.d[idx-1];
                else               eb = 1'b1;
                if (txd !== eb) mon_bad++;
                mon_cnt++;
                if (mon_cnt == 10 * cur.p) begin
                    checks++;
                    if (mon_bad != 0) begin
                        failures++;
                        $display("FAIL frame data=%h period=%0d bad_cycles=%0d required 0", cur.d, cur.p, mon_bad);
                    end
                    mon_active = 0;
                    end_cyc = ncyc;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic send(input logic [7:0] d, input bit b2b, output int acc);
        bit hs;
        int n;
        exp_t e;
        s_axis_tdata = d;
        s_axis_tvalid = 1'b1;
        n = 0;
        acc = -1;
        do begin
            hs = s_axis_tready;
            @(posedge clk); #1;
            n++;
        end while (!hs && n < 2000);
        if (!hs) begin
            checks++; failures++;
            $display("FAIL send_timeout data=%h tready=0 required 1", d);
        end else begin
            acc = pcyc;
            e.d = d;
            e.p = ((prescale == 16'd0) ? 1 : int'(prescale)) * 8;
            e.b2b = b2b;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        s_axis_tvalid = 1'b0;
        while ((sb.size() != 0 || mon_active) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_pending", sb.size() + (mon_active ? 1 : 0), 0);
    endtask

    initial begin
        int a0, a1, a2, bc;
        logic [7:0] rb;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_txd", txd, 1);
        check("reset_busy", busy, 0);
        check("reset_tready", s_axis_tready, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("release_tready", s_axis_tready, 1);
        check("release_txd", txd, 1);

        // Single byte, P=8
        prescale = 16'd1;
        send(8'hA5, 0, a0);
        s_axis_tvalid = 1'b0;
        bc = 0;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk); #1;
            if (busy) bc++;
        end
        check("single_busy_cycles", bc, 80);
        check("single_end_txd", txd, 1);
        check("single_end_busy", busy, 0);
        drain();

        // Back-to-back, P=16
        prescale = 16'd2;
        send(8'h00, 0, a0);
        check("b2b_hold_full_tready", s_axis_tready, 0);
        send(8'hFF, 1, a1);
        check("b2b_second_accept_delay", a1 - a0, 2);
        check("b2b_hold_full_tready2", s_axis_tready, 0);
        drain();

        // Backpressure with three words, P=8
        prescale = 16'd1;
        send(8'h11, 0, a0);
        send(8'h22, 1, a1);
        send(8'h33, 1, a2);
        check("bp_third_accept_delay", a2 - a1, 80);
        drain();

        // prescale=0 treated as 1; change mid-frame applies to next frame only
        prescale = 16'd0;
        send(8'h3C, 0, a0);
        s_axis_tvalid = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        prescale = 16'd4;
        send(8'hC3, 1, a1);
        drain();

        // Reset during data bit 3 with a word waiting in hold
        prescale = 16'd1;
        send(8'h99, 0, a0);
        send(8'h77, 1, a1);
        s_axis_tvalid = 1'b0;
        repeat (34) @(posedge clk);
        #1;
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset_txd", txd, 1);
        check("midreset_busy", busy, 0);
        check("midreset_tready", s_axis_tready, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postreset_tready", s_axis_tready, 1);
        repeat (40) @(posedge clk);
        #1;
        check("postreset_idle_busy", busy, 0);
        check("postreset_idle_txd", txd, 1);
        send(8'h5A, 0, a0);
        drain();

        // Loopback-style stream of 256 random bytes at P=24
        prescale = 16'd3;
        for (int i = 0; i < 256; i++) begin
            rb = 8'($urandom_range(0, 255));
            send(rb, (i != 0), a0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
